// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the controller state encoding, default operand widths and the
// constants that describe the divide-by-zero result.
package div_pkg;

    // Default dividend/quotient and divisor/remainder widths.
    localparam int DEF_DW = 8;
    localparam int DEF_VW = 4;

    // Iteration counter width for the default dividend width.
    localparam int CW = $clog2(DEF_DW);

    // Quotient reported when the divisor is zero: all ones.
    localparam logic [DEF_DW-1:0] DBZ_QUOTIENT = {DEF_DW{1'b1}};

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : div_pkg

// File: rtl/div_restore_step.sv
// One combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and reports the resulting quotient bit.
module div_restore_step
    import div_pkg::*;
#(
    parameter int VW = DEF_VW
) (
    input  logic [VW:0]   prem_in,
    input  logic          next_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   prem_out,
    output logic          q_bit
);

    localparam int PW = VW + 1;
    localparam int TW = VW + 2;

    logic [TW-1:0] trial;
    logic [TW-1:0] divisor_ext;

    // Between steps the partial remainder is below the divisor, so its MSB
    // is zero; the full register is still folded into the trial value so the
    // compare never silently drops a set bit.
    always_comb begin
        trial       = {prem_in, next_bit};
        divisor_ext = {2'b00, divisor};
        if (trial >= divisor_ext) begin
            prem_out = PW'(trial - divisor_ext);
            q_bit    = 1'b1;
        end else begin
            prem_out = PW'(trial);
            q_bit    = 1'b0;
        end
    end

endmodule : div_restore_step

// File: rtl/seq_div_u8by4.sv
// Sequential unsigned restoring divider, DW-bit dividend by VW-bit divisor.
// One quotient bit per clock with valid/ready handshakes on both sides.
// The dividend register doubles as the quotient shift register: each step
// consumes its MSB and shifts the fresh quotient bit into its LSB.
// A zero divisor skips the iteration and reports all-ones with the
// low dividend bits as remainder and div_by_zero set.
module seq_div_u8by4
    import div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // The package counter width covers the default build; other widths size
    // their own counter.
    localparam int CNT_W = (DW == DEF_DW) ? CW : $clog2(DW);

    // All-ones quotient at whatever width the block is built with.
    localparam logic [DW-1:0] DBZ_Q = {DW{DBZ_QUOTIENT[0]}};

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DW - 1);

    state_e state_q;
    state_e state_d;

    logic [DW-1:0]    shift_q;
    logic [DW-1:0]    shift_d;
    logic [VW:0]      prem_q;
    logic [VW:0]      prem_d;
    logic [VW-1:0]    divisor_q;
    logic [VW-1:0]    divisor_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [DW-1:0]    quotient_q;
    logic [DW-1:0]    quotient_d;
    logic [VW-1:0]    remainder_q;
    logic [VW-1:0]    remainder_d;
    logic             dbz_q;
    logic             dbz_d;

    logic             start_op;
    logic             divisor_zero;
    logic             last_step;
    logic [VW:0]      step_prem;
    logic             step_bit;
    logic [DW-1:0]    shift_next;

    assign start_op     = in_valid && (state_q == IDLE);
    assign divisor_zero = (divisor == '0);
    assign last_step    = (state_q == BUSY) && (count_q == '0);
    assign shift_next   = {shift_q[DW-2:0], step_bit};

    // The single step instance is reused on every BUSY cycle.
    div_restore_step #(
        .VW (VW)
    ) u_step (
        .prem_in  (prem_q),
        .next_bit (shift_q[DW-1]),
        .divisor  (divisor_q),
        .prem_out (step_prem),
        .q_bit    (step_bit)
    );

    // Controller state register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero divisors bypass BUSY, results wait for out_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_op) begin
                    state_d = divisor_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode the registered state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: load on accept, one restoring step per BUSY cycle,
    // publish the result registers only when the final step completes.
    always_comb begin
        shift_d     = shift_q;
        prem_d      = prem_q;
        divisor_d   = divisor_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start_op) begin
                    dbz_d = divisor_zero;
                    if (divisor_zero) begin
                        quotient_d  = DBZ_Q;
                        remainder_d = dividend[VW-1:0];
                    end else begin
                        shift_d   = dividend;
                        divisor_d = divisor;
                        prem_d    = '0;
                        count_d   = LAST_COUNT;
                    end
                end
            end
            BUSY: begin
                shift_d = shift_next;
                prem_d  = step_prem;
                count_d = count_q - CNT_W'(1);
                if (last_step) begin
                    quotient_d  = shift_next;
                    remainder_d = step_prem[VW-1:0];
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            prem_q      <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            prem_q      <= prem_d;
            divisor_q   <= divisor_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : seq_div_u8by4

// File: tb/tb_seq_div_u8by4.sv
// Self-checking bench for the sequential 8-by-4 restoring divider.
// Inputs change #1 after the rising edge or on the falling edge; outputs are
// sampled #1 after the rising edge.
module tb_seq_div_u8by4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_div_u8by4 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Present one operand pair and return #1 after the accepting edge.
    task automatic drive_op(input logic [7:0] a, input logic [3:0] b, output bit accepted);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        accepted = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Count rising edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat, output bit ready_leak);
        lat = 0;
        ready_leak = 1'b0;
        while (!out_valid && lat < 64) begin
            if (in_ready) ready_leak = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Hold off the consumer for 'hold' cycles, then complete the handshake.
    task automatic take_result(input int hold, output bit stable, output logic ov_after,
                               output logic ir_after);
        logic [7:0] q0;
        logic [3:0] r0;
        logic       d0;
        q0 = quotient;
        r0 = remainder;
        d0 = div_by_zero;
        stable = 1'b1;
        out_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || quotient !== q0 || remainder !== r0 || div_by_zero !== d0)
                stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        ov_after = out_valid;
        ir_after = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = 8'd0;
        divisor = 4'd0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got=%b expected=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got=%b expected=0", out_valid);
        end
        checks++;
        if (quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got q=%0d r=%0d dbz=%b expected q=0 r=0 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit acc, leak, stable;
        logic ov, ir;
        int lat;
        drive_op(8'd200, 4'd7, acc);
        checks++;
        if (!acc || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_accept accepted=%b in_ready=%b expected accepted=1 in_ready=0",
                     acc, in_ready);
        end
        // Hold a different request while busy; it must not disturb 200/7.
        in_valid = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd2;
        wait_result(lat, leak);
        checks++;
        if (lat != 8 || leak) begin
            errors++;
            $display("[TB] FAIL basic_latency got=%0d leak=%b expected=8 leak=0", lat, leak);
        end
        checks++;
        if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_200_7 got q=%0d r=%0d dbz=%b expected q=28 r=4 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        take_result(0, stable, ov, ir);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_release got out_valid=%b in_ready=%b expected 0 1", ov, ir);
        end
        // The held request is taken as soon as the block is idle again.
        drive_op(8'd9, 4'd2, acc);
        wait_result(lat, leak);
        checks++;
        if (!acc || lat != 8 || quotient !== 8'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_9_2 got q=%0d r=%0d lat=%0d expected q=4 r=1 lat=8",
                     quotient, remainder, lat);
        end
        take_result(0, stable, ov, ir);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_tab [3] = '{8'd255, 8'd255, 8'd5};
        logic [3:0] b_tab [3] = '{4'd15, 4'd1, 4'd9};
        logic [7:0] q_tab [3] = '{8'd17, 8'd255, 8'd0};
        logic [3:0] r_tab [3] = '{4'd0, 4'd0, 4'd5};
        bit acc, leak, stable;
        logic ov, ir;
        int lat;
        for (int i = 0; i < 3; i++) begin
            drive_op(a_tab[i], b_tab[i], acc);
            checks++;
            if (!acc || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_accept_%0d in_ready=%b expected 0", i, in_ready);
            end
            wait_result(lat, leak);
            checks++;
            if (lat != 8 || leak || quotient !== q_tab[i] || remainder !== r_tab[i]
                || div_by_zero !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_result_%0d got q=%0d r=%0d lat=%0d leak=%b expected q=%0d r=%0d lat=8 leak=0",
                         i, quotient, remainder, lat, leak, q_tab[i], r_tab[i]);
            end
            take_result(0, stable, ov, ir);
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_release_%0d got out_valid=%b in_ready=%b expected 0 1",
                         i, ov, ir);
            end
        end
    endtask

    task automatic test_div_by_zero();
        bit acc, leak, stable;
        logic ov, ir;
        int lat;
        drive_op(8'd13, 4'd0, acc);
        wait_result(lat, leak);
        // Result is already visible right after the accept edge.
        checks++;
        if (!acc || lat != 0) begin
            errors++;
            $display("[TB] FAIL dbz_latency got=%0d expected=0 extra edges", lat);
        end
        checks++;
        if (quotient !== 8'hFF || remainder !== 4'hD || div_by_zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dbz_13_0 got q=%h r=%h dbz=%b expected q=ff r=d dbz=1",
                     quotient, remainder, div_by_zero);
        end
        take_result(0, stable, ov, ir);
        drive_op(8'd13, 4'd2, acc);
        wait_result(lat, leak);
        checks++;
        if (lat != 8 || quotient !== 8'd6 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbz_clear_13_2 got q=%0d r=%0d dbz=%b lat=%0d expected q=6 r=1 dbz=0 lat=8",
                     quotient, remainder, div_by_zero, lat);
        end
        take_result(0, stable, ov, ir);
    endtask

    task automatic test_backpressure();
        bit acc, leak, stable;
        logic ov, ir;
        int lat;
        drive_op(8'd100, 4'd3, acc);
        wait_result(lat, leak);
        checks++;
        if (lat != 8 || quotient !== 8'd33 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_100_3 got q=%0d r=%0d lat=%0d expected q=33 r=1 lat=8",
                     quotient, remainder, lat);
        end
        take_result(20, stable, ov, ir);
        checks++;
        if (!stable) begin
            errors++;
            $display("[TB] FAIL bp_stable got stable=0 expected stable=1");
        end
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release got out_valid=%b in_ready=%b expected 0 1", ov, ir);
        end
    endtask

    task automatic test_reset_abort();
        bit acc, leak, stable, seen_valid;
        logic ov, ir;
        int lat;
        drive_op(8'd77, 4'd5, acc);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_handshake got out_valid=%b in_ready=%b expected 0 1",
                     out_valid, in_ready);
        end
        checks++;
        if (quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_outputs got q=%0d r=%0d dbz=%b expected q=0 r=0 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("[TB] FAIL abort_no_pulse got out_valid pulse=1 expected 0");
        end
        drive_op(8'd77, 4'd5, acc);
        wait_result(lat, leak);
        checks++;
        if (lat != 8 || quotient !== 8'd15 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_retry_77_5 got q=%0d r=%0d lat=%0d expected q=15 r=2 lat=8",
                     quotient, remainder, lat);
        end
        take_result(0, stable, ov, ir);
    endtask

    task automatic test_sweep();
        bit acc, leak, stable;
        logic ov, ir;
        int lat, exp_lat, sweep_fail;
        logic [7:0] av, exp_q;
        logic [3:0] bv, exp_r;
        logic exp_d;
        sweep_fail = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                av = 8'(a);
                bv = 4'(b);
                if (bv == 4'd0) begin
                    exp_q = 8'hFF;
                    exp_r = av[3:0];
                    exp_d = 1'b1;
                    exp_lat = 0;
                end else begin
                    exp_q = av / bv;
                    exp_r = 4'(av % bv);
                    exp_d = 1'b0;
                    exp_lat = 8;
                end
                repeat ($urandom_range(0, 2)) @(posedge clk);
                drive_op(av, bv, acc);
                wait_result(lat, leak);
                checks++;
                if (!acc || lat != exp_lat || quotient !== exp_q || remainder !== exp_r
                    || div_by_zero !== exp_d) begin
                    errors++;
                    sweep_fail++;
                    if (sweep_fail <= 10)
                        $display("[TB] FAIL sweep_%0d_%0d got q=%0d r=%0d dbz=%b lat=%0d expected q=%0d r=%0d dbz=%b lat=%0d",
                                 a, b, quotient, remainder, div_by_zero, lat, exp_q, exp_r, exp_d, exp_lat);
                end
                take_result($urandom_range(0, 2), stable, ov, ir);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_backpressure();
        test_reset_abort();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so a stuck design cannot hang the run.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_seq_div_u8by4
